// File: rtl/counter_down_modulus_8bit_pkg.sv
// counter_pkg: state encoding, mode constants and load clamp shared by the down counter.
package counter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  function automatic int unsigned clamp_load(input int unsigned d, input int unsigned modulus);
    return (d >= modulus) ? modulus - 1 : d;
  endfunction
endpackage

// File: rtl/counter_down_modulus_8bit.sv
// counter_down_modulus_8bit: loadable modulus-N down counter with wrap/one-shot modes and tc pulse.
module counter_down_modulus_8bit
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 47
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_in,
  input  logic             en_in,
  input  logic             mode_in,
  output logic [WIDTH-1:0] q_out,
  output logic             tc_out,
  output logic             busy_out,
  output logic             done_out
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  state_t           state, state_n;
  logic             mode_r, mode_n, tc_n, done_n;
  logic [WIDTH-1:0] q_n;
  logic             at_zero;
  assign at_zero  = (q_out == '0);
  assign busy_out = (state == RUN);
  always_comb begin
    state_n = state;
    q_n     = q_out;
    mode_n  = mode_r;
    done_n  = done_out;
    tc_n    = 1'b0;
    if (load_in) begin
      q_n     = WIDTH'(clamp_load(32'(d_in), 32'(MODULUS)));
      mode_n  = mode_in;
      state_n = RUN;
      done_n  = 1'b0;
    end else if (state == RUN && en_in) begin
      tc_n    = at_zero;
      q_n     = !at_zero ? q_out - 1'b1 : (mode_r == MODE_ONESHOT ? '0 : TOP);
      state_n = (at_zero && mode_r == MODE_ONESHOT) ? DONE : RUN;
      done_n  = at_zero && mode_r == MODE_ONESHOT;
    end
  end
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state    <= IDLE;
      q_out    <= '0;
      mode_r   <= MODE_WRAP;
      tc_out   <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state    <= state_n;
      q_out    <= q_n;
      mode_r   <= mode_n;
      tc_out   <= tc_n;
      done_out <= done_n;
    end
  end
endmodule

// File: doc/counter_down_modulus_8bit.md
Name: counter_down_modulus_8bit

Overview:
Loadable modulus-N down counter, the count-down counterpart of the team's modulus up counter. It decrements from a loaded value to 0, then either wraps to MODULUS-1 or stops, depending on the mode latched at load. It drives a one-cycle terminal-count (borrow) pulse and busy/done status for use as a programmable interval timer or cascaded prescaler stage.

Parameters:
WIDTH, 8, counter and load-data width in bits
MODULUS, 47, count range is MODULUS-1 down to 0; legal range 2..2**WIDTH

Ports:
clk  input  1  rising-edge clock
reset_al_in  input  1  reset, asynchronous, active-low
d_in  input  WIDTH  load value
load_in  input  1  synchronous load strobe; has priority over counting
en_in  input  1  count enable; 0 = hold
mode_in  input  1  0 = wrap (reload MODULUS-1), 1 = one-shot (stop at 0); sampled only on load
q_out  output  WIDTH  current count, registered
tc_out  output  1  terminal-count pulse, registered, 1 cycle
busy_out  output  1  high while in RUN
done_out  output  1  sticky high in DONE, cleared by next load

Behaviour:
- Reset (reset_al_in=0, immediate, asynchronous): q_out=0, tc_out=0, busy_out=0, done_out=0, mode_r=0, state=IDLE.
- States: IDLE (post-reset, holds), RUN (counting), DONE (one-shot finished, holds 0).
- Load (any state, load_in=1 on a clock edge):
  - q_out <= d_in; if d_in >= MODULUS, q_out <= MODULUS-1 (clamp).
  - mode_r <= mode_in; state <= RUN; done_out <= 0; tc_out <= 0.
  - Load wins over every simultaneous count or terminal event. No tc pulse is generated on that edge.
- RUN with load_in=0:
  - en_in=0: all registers hold; tc_out <= 0.
  - en_in=1 and q_out != 0: q_out <= q_out - 1; tc_out <= 0.
  - en_in=1, q_out == 0, mode_r=0: q_out <= MODULUS-1; tc_out <= 1; stay in RUN.
  - en_in=1, q_out == 0, mode_r=1: q_out holds 0; tc_out <= 1; state <= DONE; done_out <= 1.
- IDLE and DONE with load_in=0: q_out holds, tc_out <= 0, en_in is ignored.
- busy_out = (state == RUN). It is a decode of the state register, with no extra latency.
- Period in wrap mode with continuous enable is exactly MODULUS cycles per tc_out pulse.
- Latency: the output reflects load/count on the edge following the request. tc_out is high for exactly the cycle after the 0-underflow edge.
- Changing mode_in while in RUN has no effect.
- Arithmetic is unsigned WIDTH-bit. The 0 to 2**WIDTH-1 wrap never occurs because the wrap target is MODULUS-1.
- Reset asserted mid-RUN aborts immediately. After release, the block waits in IDLE for a load.

Decomposition:
- Shared package counter_pkg:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - mode constants: MODE_WRAP=1'b0, MODE_ONESHOT=1'b1.
  - pure clamp function: load value limited to MODULUS-1.
- No sub-module. One sequential process for state/q/tc/done, plus the busy decode.

Test Plan:
- Reset mid-run: load 20, count 3 cycles, drop reset_al_in between edges -> q_out=0, tc_out=0, busy_out=0, done_out=0 at once; it stays in IDLE after release until a load.
- Wrap mode: load d_in=5, mode 0, en=1 -> q_out 5,4,3,2,1,0,46,45; tc_out=1 only in the cycle q_out=46; busy_out stays 1.
- One-shot mode: load 3, mode 1, en=1 -> q_out 3,2,1,0,0; tc_out one pulse; done_out=1 and busy_out=0 from the same cycle; further en has no effect.
- Clamp and hold: load d_in=200 -> q_out=46; en=0 for 4 cycles -> q_out stays 46, tc_out=0.
- Load collision: in wrap mode with q_out=0 and en=1, assert load_in with d_in=9 -> q_out=9, tc_out stays 0.
- Reload after DONE: load 2 with mode 0 -> done_out clears, busy_out=1, q_out 2,1,0,46.
